// File: rtl/fir_ap_ctrl.sv
// FIR block controller: ap_ctrl/data_length/tap register map, run sequencer, tap BRAM arbiter.
// Define FIR_AP_CTRL_PERF_EN to add a RUN-cycle counter readable at 0x14.
module fir_ap_ctrl #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_wr_en,
  input  logic [pADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wr_data,
  input  logic                   cfg_rd_en,
  input  logic [pADDR_WIDTH-1:0] cfg_rd_addr,
  output logic [pDATA_WIDTH-1:0] cfg_rd_data,
  output logic                   cfg_rd_valid,
  input  logic                   sm_hs,
  output logic                   eng_en,
  input  logic [pADDR_WIDTH-1:0] eng_tap_addr,
  output logic                   data_clr_we,
  output logic [pADDR_WIDTH-1:0] data_clr_A,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam int unsigned ClrW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [ClrW-1:0]        ClrLast  = ClrW'(Tape_Num - 1);
  localparam logic [pADDR_WIDTH-1:0] CtrlAddr = '0;
  localparam logic [pADDR_WIDTH-1:0] LenAddr  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] TapEnd   = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TapBase) && (a < TapEnd) && (a[1:0] == 2'b00);
  endfunction

  state_e                 state_q, state_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [ClrW-1:0]        clr_cnt_q, clr_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_tap_q, rd_tap_d;
  logic [pDATA_WIDTH-1:0] rd_word_q, rd_word_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [pADDR_WIDTH-1:0] rd_pend_addr_q, rd_pend_addr_d;

  logic                   wr_ok, wr_tap, rd_tap_new, rd_req, rd_issue, start;
  logic [pADDR_WIDTH-1:0] rd_addr;

`ifdef FIR_AP_CTRL_PERF_EN
  localparam logic [pADDR_WIDTH-1:0] PerfAddr = pADDR_WIDTH'(32'h14);
  logic [31:0] perf_q, perf_d;
`endif

  // A tap write owns the BRAM port; a colliding tap read waits one cycle in rd_pend_q.
  always_comb begin
    wr_ok      = cfg_wr_en & ap_idle_q;
    wr_tap     = wr_ok & is_tap(cfg_wr_addr);
    rd_tap_new = cfg_rd_en & ap_idle_q & is_tap(cfg_rd_addr);
    rd_req     = rd_pend_q | rd_tap_new;
    rd_addr    = rd_pend_q ? rd_pend_addr_q : cfg_rd_addr;
    rd_issue   = rd_req & ~wr_tap;
    start      = (state_q == StIdle) & wr_ok & (cfg_wr_addr == CtrlAddr) & cfg_wr_data[0];
  end

  always_comb begin
    rd_valid_d     = rd_issue | (cfg_rd_en & ~rd_tap_new);
    rd_tap_d       = rd_issue;
    rd_pend_d      = rd_req & wr_tap;
    rd_pend_addr_d = rd_addr;
    rd_word_d      = '0;
    if (cfg_rd_addr == CtrlAddr) begin
      rd_word_d = pDATA_WIDTH'({ap_idle_q, ap_done_q, ap_start_q});
    end else if (cfg_rd_addr == LenAddr) begin
      rd_word_d = data_length_q;
`ifdef FIR_AP_CTRL_PERF_EN
    end else if (cfg_rd_addr == PerfAddr) begin
      rd_word_d = pDATA_WIDTH'(perf_q);
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ap_start_d    = ap_start_q;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    data_length_d = data_length_q;
    out_cnt_d     = out_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    if (cfg_rd_en && (cfg_rd_addr == CtrlAddr) && ap_done_q) ap_done_d = 1'b0;
    if (wr_ok && (cfg_wr_addr == LenAddr)) data_length_d = cfg_wr_data;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          ap_start_d = 1'b1;
          ap_idle_d  = 1'b0;
          ap_done_d  = 1'b0;
          out_cnt_d  = '0;
          clr_cnt_d  = '0;
        end
      end
      StClear: begin
        ap_start_d = 1'b0;
        clr_cnt_d  = clr_cnt_q + ClrW'(1);
        if (clr_cnt_q == ClrLast) begin
          state_d = (data_length_q == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (sm_hs) begin
          out_cnt_d = out_cnt_q + pDATA_WIDTH'(1);
          if (out_cnt_q == data_length_q - pDATA_WIDTH'(1)) state_d = StDone;
        end
      end
      StDone: begin
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q        <= StIdle;
      ap_start_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      ap_idle_q      <= 1'b1;
      data_length_q  <= '0;
      out_cnt_q      <= '0;
      clr_cnt_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_tap_q       <= 1'b0;
      rd_word_q      <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      ap_start_q     <= ap_start_d;
      ap_done_q      <= ap_done_d;
      ap_idle_q      <= ap_idle_d;
      data_length_q  <= data_length_d;
      out_cnt_q      <= out_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_tap_q       <= rd_tap_d;
      rd_word_q      <= rd_word_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_addr_q <= rd_pend_addr_d;
    end
  end

`ifdef FIR_AP_CTRL_PERF_EN
  always_comb begin
    perf_d = perf_q;
    if (start) begin
      perf_d = '0;
    end else if ((state_q == StRun) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) perf_q <= '0;
    else             perf_q <= perf_d;
  end
`endif

  always_comb begin
    eng_en       = (state_q == StRun);
    data_clr_we  = (state_q == StClear);
    data_clr_A   = data_clr_we ? pADDR_WIDTH'({clr_cnt_q, 2'b00}) : '0;
    tap_EN       = 1'b1;
    tap_WE       = wr_tap ? 4'hF : 4'h0;
    tap_Di       = wr_tap ? cfg_wr_data : '0;
    if ((state_q == StClear) || (state_q == StRun)) begin
      tap_A = eng_tap_addr;
    end else if (wr_tap) begin
      tap_A = cfg_wr_addr - TapBase;
    end else if (rd_issue) begin
      tap_A = rd_addr - TapBase;
    end else begin
      tap_A = '0;
    end
    cfg_rd_valid = rd_valid_q;
    cfg_rd_data  = rd_valid_q ? (rd_tap_q ? tap_Do : rd_word_q) : '0;
  end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Bench for fir_ap_ctrl: timeline-based model of run/register behaviour, per-cycle compare,
// directed scenarios with literal expectations, then randomized runs.
module tb_fir_ap_ctrl;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TN = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic          cfg_rd_en = 1'b0;
  logic [AW-1:0] cfg_rd_addr = '0;
  logic [DW-1:0] cfg_rd_data;
  logic          cfg_rd_valid;
  logic          sm_hs = 1'b0;
  logic          eng_en;
  logic [AW-1:0] eng_tap_addr = '0;
  logic          data_clr_we;
  logic [AW-1:0] data_clr_A;
  logic          tap_EN;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Di;
  logic [DW-1:0] tap_Do = '0;
  logic [DW-1:0] tap_mem [16] = '{default: '0};

  fir_ap_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TN)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
    .cfg_rd_valid(cfg_rd_valid), .sm_hs(sm_hs), .eng_en(eng_en), .eng_tap_addr(eng_tap_addr),
    .data_clr_we(data_clr_we), .data_clr_A(data_clr_A), .tap_EN(tap_EN), .tap_WE(tap_WE),
    .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM stand-in, one-cycle read latency.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= tap_mem[tap_A[5:2]];
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          act = 1'b0;
  int          st_cyc = 0;
  int          dn_cyc = -1;
  logic [31:0] hs_seen = '0;
  bit          m_idle = 1'b1;
  bit          m_done = 1'b0;
  bit          m_start = 1'b0;
  logic [31:0] m_len = '0;
  logic [31:0] m_perf = '0;
  logic [31:0] m_taps [TN] = '{default: '0};
  bit          ev = 1'b0;
  logic [31:0] ed = '0;
  bit          pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  function automatic bit is_tap(input logic [AW-1:0] a);
    return (a >= AW'(32'h20)) && (a < AW'(32'h20 + 4 * TN)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int tap_idx(input logic [AW-1:0] a);
    return int'((a - AW'(32'h20)) >> 2);
  endfunction

  function bit m_clear();
    return act && (cyc > st_cyc) && (cyc <= st_cyc + TN);
  endfunction

  function bit m_run();
    return act && (cyc > st_cyc + TN) && (dn_cyc < 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Compare outputs for this cycle, then advance the model across the clock edge.
  task automatic tick();
    logic [AW-1:0] exp_a;
    bit have_a, wr_tap, rd_tap, clr, run, dn, idle_pre;
    #1;
    wr_tap = cfg_wr_en && m_idle && is_tap(cfg_wr_addr);
    rd_tap = cfg_rd_en && m_idle && is_tap(cfg_rd_addr);
    clr = m_clear();
    run = m_run();
    chk("eng_en", 32'(eng_en), 32'(run));
    chk("data_clr_we", 32'(data_clr_we), 32'(clr));
    if (clr) chk("data_clr_A", 32'(data_clr_A), 32'(4 * (cyc - st_cyc - 1)));
    chk("tap_EN", 32'(tap_EN), 32'd1);
    chk("tap_WE", 32'(tap_WE), wr_tap ? 32'hF : 32'h0);
    have_a = 1'b1;
    exp_a = '0;
    if (wr_tap) begin
      exp_a = cfg_wr_addr - AW'(32'h20);
      chk("tap_Di", tap_Di, cfg_wr_data);
    end else if (pend) begin
      exp_a = pend_addr - AW'(32'h20);
    end else if (rd_tap) begin
      exp_a = cfg_rd_addr - AW'(32'h20);
    end else if (clr || run) begin
      exp_a = eng_tap_addr;
    end else begin
      have_a = 1'b0;
    end
    if (have_a) chk("tap_A", 32'(tap_A), 32'(exp_a));
    chk("cfg_rd_valid", 32'(cfg_rd_valid), 32'(ev));
    if (ev) chk("cfg_rd_data", cfg_rd_data, ed);

    @(posedge axis_clk);
    dn = act && (dn_cyc == cyc);
    idle_pre = m_idle;
    ev = 1'b0;
    if (!axis_rst_n) begin
      act = 1'b0; m_idle = 1'b1; m_done = 1'b0; m_start = 1'b0;
      m_len = '0; m_perf = '0; pend = 1'b0; dn_cyc = -1;
    end else begin
      if (pend) begin
        ev = 1'b1;
        ed = m_taps[tap_idx(pend_addr)];
        pend = 1'b0;
      end
      if (cfg_rd_en) begin
        if (rd_tap && wr_tap) begin
          pend = 1'b1;
          pend_addr = cfg_rd_addr;
        end else begin
          ev = 1'b1;
          if (rd_tap) ed = m_taps[tap_idx(cfg_rd_addr)];
          else if (cfg_rd_addr == AW'(0)) ed = {29'b0, m_idle, m_done, m_start};
          else if (cfg_rd_addr == AW'(32'h10)) ed = m_len;
`ifdef FIR_AP_CTRL_PERF_EN
          else if (cfg_rd_addr == AW'(32'h14)) ed = m_perf;
`endif
          else ed = '0;
          if ((cfg_rd_addr == AW'(0)) && m_done) m_done = 1'b0;
        end
      end
      if (run) begin
        if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        if (sm_hs) begin
          hs_seen = hs_seen + 1;
          if (hs_seen == m_len) dn_cyc = cyc + 1;
        end
      end
      if (act && (cyc == st_cyc + 1)) m_start = 1'b0;
      if (dn) begin
        m_done = 1'b1; m_idle = 1'b1; act = 1'b0; dn_cyc = -1;
      end
      if (cfg_wr_en && idle_pre) begin
        if ((cfg_wr_addr == AW'(0)) && cfg_wr_data[0]) begin
          act = 1'b1; st_cyc = cyc; dn_cyc = (m_len == 0) ? cyc + TN + 1 : -1;
          m_start = 1'b1; m_idle = 1'b0; m_done = 1'b0; hs_seen = '0; m_perf = '0;
        end else if (cfg_wr_addr == AW'(32'h10)) begin
          m_len = cfg_wr_data;
        end else if (is_tap(cfg_wr_addr)) begin
          m_taps[tap_idx(cfg_wr_addr)] = cfg_wr_data;
        end
      end
    end
    cyc++;
    @(negedge axis_clk);
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    sm_hs = 1'b0;
    eng_tap_addr = AW'(4 * $urandom_range(0, TN - 1));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    bit got = 1'b0;
    d = '0;
    cfg_rd_en = 1'b1; cfg_rd_addr = a;
    tick();
    for (int k = 0; k < 3 && !got; k++) begin
      #1;
      if (cfg_rd_valid) begin
        got = 1'b1;
        d = cfg_rd_data;
      end
      tick();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got no cfg_rd_valid expected one for addr 0x%0h", a);
    end
  endtask

  function automatic logic [AW-1:0] rand_rd_addr();
    case ($urandom_range(0, 5))
      0: return AW'(0);
      1: return AW'(32'h10);
      2: return AW'(32'h14);
      3: return AW'(32'h08);
      4: return AW'(32'h22);
      default: return AW'(32'h20 + 4 * $urandom_range(0, TN + 1));
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    bit seen;
    int g;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    tick();
    rd(AW'(0), d);           chk("rst_ctrl", d, 32'h4);

    for (int i = 0; i < TN; i++) wr(AW'(32'h20 + 4 * i), 32'(i + 1));
    rd(AW'(32'h34), d);      chk("tap5", d, 32'd6);

    // Write and read of the same tap in one cycle: read lands two cycles later.
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(32'h28); cfg_wr_data = 32'h33;
    cfg_rd_en = 1'b1; cfg_rd_addr = AW'(32'h28);
    tick();
    #1 chk("defer_gap", 32'(cfg_rd_valid), 32'd0);
    tick();
    #1 chk("defer_valid", 32'(cfg_rd_valid), 32'd1);
    chk("defer_data", cfg_rd_data, 32'h33);
    tick();
    wr(AW'(32'h28), 32'd3);

    wr(AW'(32'h10), 32'd3);
    wr(AW'(0), 32'd1);
    repeat (TN) tick();
    #1 chk("run_eng_en", 32'(eng_en), 32'd1);
    wr(AW'(32'h2C), 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      sm_hs = 1'b1; tick(); tick();
    end
    rd(AW'(0), d);           chk("done_ctrl", d, 32'h6);
    rd(AW'(0), d);           chk("done_cleared", d, 32'h4);
    rd(AW'(32'h2C), d);      chk("tap3_kept", d, 32'd4);

    wr(AW'(32'h10), 32'd0);
    wr(AW'(0), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !m_idle; k++) begin
      #1 if (eng_en) seen = 1'b1;
      tick();
    end
    chk("len0_no_eng", 32'(seen), 32'd0);
    rd(AW'(0), d);           chk("len0_done", d, 32'h6);

    wr(AW'(32'h10), 32'd1);
    wr(AW'(0), 32'd1);
    repeat (TN) tick();
    sm_hs = 1'b1; tick();
    cfg_rd_en = 1'b1; cfg_rd_addr = AW'(0);
    tick();
    #1 chk("donecyc_rd", cfg_rd_data, 32'h0);
    tick();
    rd(AW'(0), d);           chk("donecyc_kept", d, 32'h6);

    wr(AW'(32'h10), 32'd5);
    wr(AW'(0), 32'd1);
    repeat (TN + 3) tick();
    axis_rst_n = 1'b0;
    tick();
    axis_rst_n = 1'b1;
    #1 chk("rst_abort_eng", 32'(eng_en), 32'd0);
    rd(AW'(0), d);           chk("rst_abort_ctrl", d, 32'h4);

    wr(AW'(32'h10), 32'd2);
    wr(AW'(0), 32'd1);
    repeat (TN) tick();
    for (int r = 1; r <= 9; r++) begin
      sm_hs = (r == 4) || (r == 9);
      tick();
    end
    tick();
    rd(AW'(32'h14), d);
`ifdef FIR_AP_CTRL_PERF_EN
    chk("perf", d, 32'd9);
`else
    chk("perf_absent", d, 32'd0);
`endif

    for (int run = 0; run < 25; run++) begin
      repeat ($urandom_range(1, 4)) begin
        if ($urandom_range(0, 1) == 0) begin
          wr(AW'(32'h20 + 4 * $urandom_range(0, TN - 1)), $urandom);
        end else begin
          cfg_rd_en = 1'b1; cfg_rd_addr = rand_rd_addr(); tick();
        end
      end
      wr(AW'(32'h10), 32'($urandom_range(0, 6)));
      wr(AW'(0), 32'd1);
      g = 0;
      while (!m_idle && g < 200) begin
        sm_hs = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) begin
          cfg_rd_en = 1'b1; cfg_rd_addr = rand_rd_addr();
        end else if ($urandom_range(0, 7) == 0) begin
          cfg_wr_en = 1'b1; cfg_wr_data = $urandom;
          cfg_wr_addr = ($urandom_range(0, 1) == 0) ? AW'(32'h10) : AW'(32'h24);
        end
        tick();
        g++;
      end
      if (g >= 200) chk("run_timeout", 32'(m_idle), 32'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
